// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: UART receiver with loopback, framing-error/break handling, LED echo and line-edge counter
module uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned LED_W        = 4,
  parameter bit          LOOPBACK_INV = 1'b0
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 uart_txd_in,
  output logic                 uart_rxd_out,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic [LED_W-1:0]     led,
  output logic [15:0]          edge_cnt
);
  localparam int unsigned   TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    I_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic                 r_rxs_d;
  logic [15:0]          r_edge_cnt;
  logic [TW-1:0]        r_timer;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic [LED_W-1:0]     r_led;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 w_rxs;
  logic                 w_edge;

  assign w_rxs        = r_sync[1];
  assign w_edge       = w_rxs ^ r_rxs_d;
  assign uart_rxd_out = uart_txd_in ^ LOOPBACK_INV;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign frame_err    = r_frame_err;
  assign led          = r_led;
  assign edge_cnt     = r_edge_cnt;

  // Two-flop synchronizer (idle-high) and saturating count of synchronized line transitions
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_sync     <= 2'b11;
      r_rxs_d    <= 1'b1;
      r_edge_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[0], uart_txd_in};
      r_rxs_d <= w_rxs;
      if (w_edge && r_edge_cnt != 16'hFFFF)
        r_edge_cnt <= r_edge_cnt + 16'd1;
    end
  end

  // Receive FSM: mid-bit sampling from the start-bit centre, registered one-cycle pulses
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_led       <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state <= S_START;
            r_timer <= '0;
          end
        end
        S_START: begin
          if (r_timer == T_HALF) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= w_rxs ? S_IDLE : S_DATA;
          end else
            r_timer <= r_timer + 1'b1;
        end
        S_DATA: begin
          if (r_timer == T_FULL) begin
            r_timer <= '0;
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + 4'd1;
            if (r_idx == I_LAST)
              r_state <= S_STOP;
          end else
            r_timer <= r_timer + 1'b1;
        end
        S_STOP: begin
          if (r_timer == T_FULL) begin
            r_timer <= '0;
            if (w_rxs) begin
              r_rx_data  <= r_shift;
              r_led      <= r_shift[LED_W-1:0];
              r_rx_valid <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else
            r_timer <= r_timer + 1'b1;
        end
        S_BREAK: begin
          if (w_rxs)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed scoreboard bench for uart_rx_monitor
module tb_uart_rx_monitor;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txd = 1'b1;
  logic       rxd, rxd_i;
  logic [7:0] rx_data, rx_data_i;
  logic       rx_valid, rx_valid_i, frame_err, frame_err_i;
  logic [3:0] led, led_i;
  logic [15:0] edge_cnt, edge_cnt_i;

  int n_cmp = 0, n_bad = 0;
  int valid_cnt = 0, ferr_cnt = 0, n_push = 0, exp_edges = 0;
  int base_v = 0;
  bit mon_en = 1'b1, overlap = 1'b0;
  logic pv = 1'b0, pf = 1'b0;
  logic [7:0] mon_e;
  logic [7:0] dd;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .LED_W(4), .LOOPBACK_INV(1'b0)) dut (
    .CLK100MHZ(clk), .reset(rst_n), .uart_txd_in(txd), .uart_rxd_out(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .led(led), .edge_cnt(edge_cnt)
  );

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .LED_W(4), .LOOPBACK_INV(1'b1)) dut_inv (
    .CLK100MHZ(clk), .reset(rst_n), .uart_txd_in(txd), .uart_rxd_out(rxd_i),
    .rx_data(rx_data_i), .rx_valid(rx_valid_i), .frame_err(frame_err_i), .led(led_i), .edge_cnt(edge_cnt_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input logic v, input int n);
    if (v !== txd && exp_edges < 65535) exp_edges++;
    txd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input bit push);
    if (push) begin
      exp_q.push_back(d);
      n_push++;
    end
    set_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) set_line(d[i], CPB);
    set_line(stop, CPB);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pop the scoreboard on every rx_valid, track pulse rules
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if ((rx_valid && frame_err) || (rx_valid && pv) || (frame_err && pf)) overlap = 1'b1;
      pv = rx_valid;
      pf = frame_err;
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) chk("spurious_valid", {31'd0, rx_valid}, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(mon_e));
          chk("led", 32'(led), 32'(mon_e[3:0]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    txd = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("rst_inv_pulses", {30'd0, rx_valid_i, frame_err_i}, 32'd0);
    chk("rst_loop", {31'd0, rxd}, {31'd0, txd});
    chk("rst_loop_inv", {31'd0, rxd_i}, {31'd0, ~txd});
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send(8'hA5, 1'b1, 1'b1);
    set_line(1'b1, CPB);
    drain("drain_a5");
    chk("a5_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("a5_ferr_cnt", 32'(ferr_cnt), 32'd0);
    chk("a5_rx_data", 32'(rx_data), 32'hA5);
    chk("a5_led", 32'(led), 32'h5);
    chk("a5_edge_cnt", 32'(edge_cnt), 32'(exp_edges));
    chk("inv_rx_data", 32'(rx_data_i), 32'hA5);
    chk("inv_led", 32'(led_i), 32'h5);
    chk("inv_edge_cnt", 32'(edge_cnt_i), 32'(exp_edges));

    send(8'h3C, 1'b0, 1'b0);
    set_line(1'b0, 40);
    chk("brk_ferr_cnt", 32'(ferr_cnt), 32'd1);
    chk("brk_rx_data_hold", 32'(rx_data), 32'hA5);
    chk("brk_valid_cnt", 32'(valid_cnt), 32'd1);
    set_line(1'b1, 2 * CPB);
    send(8'h81, 1'b1, 1'b1);
    set_line(1'b1, CPB);
    drain("drain_81");
    chk("81_valid_cnt", 32'(valid_cnt), 32'd2);
    chk("81_rx_data", 32'(rx_data), 32'h81);
    chk("81_edge_cnt", 32'(edge_cnt), 32'(exp_edges));

    base_v = valid_cnt;
    set_line(1'b0, 4);
    set_line(1'b1, 3 * CPB);
    chk("glitch_edge_cnt", 32'(edge_cnt), 32'(exp_edges));
    chk("glitch_valid_cnt", 32'(valid_cnt), 32'(base_v));
    chk("glitch_ferr_cnt", 32'(ferr_cnt), 32'd1);

    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    send(8'h55, 1'b1, 1'b1);
    set_line(1'b1, CPB);
    drain("drain_b2b");
    chk("b2b_valid_cnt", 32'(valid_cnt), 32'(base_v + 3));
    chk("b2b_edge_cnt", 32'(edge_cnt), 32'(exp_edges));

    base_v = valid_cnt;
    dd = 8'hF0;
    set_line(1'b0, CPB);
    for (int i = 0; i < 3; i++) set_line(dd[i], CPB);
    rst_n = 1'b0;
    for (int i = 3; i < 8; i++) set_line(dd[i], CPB);
    set_line(1'b1, 2 * CPB);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    chk("midrst_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("midrst_loop", {31'd0, rxd}, {31'd0, txd});
    rst_n = 1'b1;
    exp_edges = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_edge_cnt", 32'(edge_cnt), 32'd0);
    send(8'h12, 1'b1, 1'b1);
    set_line(1'b1, CPB);
    drain("drain_12");
    chk("12_valid_cnt", 32'(valid_cnt), 32'(base_v + 1));
    chk("12_rx_data", 32'(rx_data), 32'h12);
    chk("12_edge_cnt", 32'(edge_cnt), 32'(exp_edges));
    chk("12_ferr_cnt", 32'(ferr_cnt), 32'd1);

    chk("pulse_rules", {31'd0, overlap}, 32'd0);
    chk("total_valid", 32'(valid_cnt), 32'(n_push));

    mon_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      txd = 1'($urandom);
      rst_n = ((i / 16) % 2) == 1 ? 1'b0 : 1'b1;
      #1;
      chk("loop", {31'd0, rxd}, {31'd0, txd});
      chk("loop_inv", {31'd0, rxd_i}, {31'd0, ~txd});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
